renode_ahb_arbiter: RTL and testbench
=====================================

// Module: renode_ahb_arbiter
// PURPOSE
//  AHB-Lite multi-manager arbiter and bus multiplexer. It lets NUM_MANAGERS HDL managers share one
//  subordinate port, such as the Renode-backed AHB subordinate.
//  - Round-robin grant with parking on the last owner.
//  - Burst and lock aware: a grant is never moved mid-burst or during a locked sequence.
//  - Routes the address phase from the granted manager and HWDATA from the data-phase owner.
// PARAMETERS
//  NUM_MANAGERS  2   number of requesting managers (2..8)
//  ADDR_WIDTH    32  HADDR width
//  DATA_WIDTH    32  HWDATA width
//  IDX_W         $clog2(NUM_MANAGERS)  derived, manager index width
// PORTS
//  HCLK         in   1     bus clock
//  HRESETn      in   1     asynchronous reset, active low
//  m_HBUSREQ    in   N     per-manager bus request
//  m_HMASTLOCK  in   N     per-manager lock
//  m_HADDR      in   N*AW  per-manager address, manager i at [i*AW +: AW]
//  m_HTRANS     in   N*2   per-manager HTRANS
//  m_HWRITE     in   N     per-manager HWRITE
//  m_HSIZE      in   N*3   per-manager HSIZE
//  m_HBURST     in   N*3   per-manager HBURST
//  m_HWDATA     in   N*DW  per-manager write data
//  m_HGRANT     out  N     one-hot grant; manager i drives its address phase when HGRANT[i] && HREADY
//  HREADY       in   1     shared ready from the subordinate; also fanned to all managers
//  s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HMASTLOCK  out  AW/2/1/3/3/1
//               address and control of the granted manager
//  s_HWDATA     out  DW    write data of the data-phase owner
//  addr_owner   out  IDX_W index of the granted (address-phase) manager
//  data_owner   out  IDX_W index of the data-phase manager
// BEHAVIOUR
//  Reset (async, HRESETn=0):
//   - m_HGRANT=1 (manager 0 parked); addr_owner=0; data_owner=0; beats_left=0.
//   - s_HTRANS forced to IDLE(0) while HRESETn=0.
//   - Reset mid-burst aborts the burst; no partial state survives.
//  Address mux:
//   - s_* address/control = inputs of the manager at addr_owner; combinational, zero latency.
//  Data pipeline:
//   - On posedge with HREADY=1: data_owner <= addr_owner.
//   - s_HWDATA = m_HWDATA[data_owner].
//   - With HREADY=0, data_owner and addr_owner hold.
//  Burst counter beats_left (5 bits), on posedge with HREADY=1, using the owner's HTRANS/HBURST:
//   - NONSEQ + INCR4/WRAP4 loads 3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
//   - NONSEQ + SINGLE/INCR loads 0.
//   - SEQ with beats_left>0 decrements.
//   - IDLE clears to 0 (covers early termination after HRESP ERROR).
//   - BUSY holds.
//  last = accepted transfer ends the owner's sequence:
//   - HTRANS=IDLE; or
//   - NONSEQ with SINGLE; or
//   - SEQ with beats_left==1; or
//   - INCR (NONSEQ/SEQ) while m_HBUSREQ[owner]=0.
//  Rearbitration:
//   - rearb = HREADY && last && !(m_HMASTLOCK[owner] && HTRANS!=IDLE).
//   - BUSY never permits rearbitration.
//  Round-robin:
//   - next = first i in order owner+1, owner+2, ... (mod N) with m_HBUSREQ[i]=1.
//   - If the owner alone requests, it keeps the grant.
//   - If no manager requests, the grant parks on the current owner.
//  Grant update:
//   - On posedge with rearb: addr_owner <= next; m_HGRANT <= onehot(next).
//   - Handover is one cycle: the new owner's NONSEQ appears on s_* the cycle after the grant changes.
//   - The old owner's pending data phase still completes via data_owner.
//  Simultaneous events:
//   - Request and release in the same cycle: round-robin evaluates the current-cycle m_HBUSREQ.
//   - HREADY=0 freezes all state.
//  Width: the owner index wraps modulo NUM_MANAGERS.
//  No combinational path from HREADY to m_HGRANT.
// TESTING
//  1. Reset, no requests.
//     -> m_HGRANT=01, s_HTRANS=IDLE, addr_owner=0; parks indefinitely.
//  2. M1 requests; M0 idle.
//     -> grant to M1 one cycle later; NONSEQ write 0x100/0xDEADBEEF reaches s_HADDR/s_HWDATA in order.
//  3. M0 INCR4 at 0x40 while M1 requests.
//     -> M0 keeps grant for all 4 beats; M1 granted on the edge accepting beat 4.
//  4. M0 and M1 request continuously with SINGLE transfers.
//     -> grants alternate 0,1,0,1 every transfer.
//  5. M0 locked sequence (HMASTLOCK=1, two NONSEQ) with HREADY low 3 cycles mid-sequence.
//     -> no handover until lock drops; data_owner stable while HREADY=0.
//  6. HRESETn pulsed low mid INCR8 of M1.
//     -> immediate return to reset values; beats_left=0; M0 parked.

Source files
------------

// File: rtl/renode_ahb_arbiter.sv
// AHB-Lite round-robin arbiter and bus mux: zero-latency address mux, one-cycle registered grant handover.
// Holds all state while HREADY is low; never moves the grant mid-burst or during a locked sequence.
module renode_ahb_arbiter #(
  parameter int NUM_MANAGERS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  localparam int IDX_W       = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NUM_MANAGERS-1:0]            m_HBUSREQ,
  input  logic [NUM_MANAGERS-1:0]            m_HMASTLOCK,
  input  logic [NUM_MANAGERS*ADDR_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MANAGERS*2-1:0]          m_HTRANS,
  input  logic [NUM_MANAGERS-1:0]            m_HWRITE,
  input  logic [NUM_MANAGERS*3-1:0]          m_HSIZE,
  input  logic [NUM_MANAGERS*3-1:0]          m_HBURST,
  input  logic [NUM_MANAGERS*DATA_WIDTH-1:0] m_HWDATA,
  output logic [NUM_MANAGERS-1:0]            m_HGRANT,
  input  logic                               HREADY,
  output logic [ADDR_WIDTH-1:0]              s_HADDR,
  output logic [1:0]                         s_HTRANS,
  output logic                               s_HWRITE,
  output logic [2:0]                         s_HSIZE,
  output logic [2:0]                         s_HBURST,
  output logic                               s_HMASTLOCK,
  output logic [DATA_WIDTH-1:0]              s_HWDATA,
  output logic [IDX_W-1:0]                   addr_owner,
  output logic [IDX_W-1:0]                   data_owner
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  logic [IDX_W-1:0] addr_owner_q, addr_owner_d;
  logic [IDX_W-1:0] data_owner_q, data_owner_d;
  logic [IDX_W-1:0] next_idx;
  logic [4:0]       beats_left_q, beats_left_d;
  logic [1:0]       own_trans;
  logic [2:0]       own_burst;
  logic             own_lock, own_req, last, rearb;
  int               aidx, didx;

  assign aidx = int'(addr_owner_q);
  assign didx = int'(data_owner_q);

  assign own_trans   = m_HTRANS[aidx*2 +: 2];
  assign own_burst   = m_HBURST[aidx*3 +: 3];
  assign own_lock    = m_HMASTLOCK[addr_owner_q];
  assign own_req     = m_HBUSREQ[addr_owner_q];

  assign s_HADDR     = m_HADDR[aidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_HTRANS    = HRESETn ? own_trans : TR_IDLE;
  assign s_HWRITE    = m_HWRITE[addr_owner_q];
  assign s_HSIZE     = m_HSIZE[aidx*3 +: 3];
  assign s_HBURST    = own_burst;
  assign s_HMASTLOCK = own_lock;
  assign s_HWDATA    = m_HWDATA[didx*DATA_WIDTH +: DATA_WIDTH];
  assign addr_owner  = addr_owner_q;
  assign data_owner  = data_owner_q;

  // Grant is decoded from the registered owner, so HREADY never reaches it combinationally.
  always_comb begin
    m_HGRANT = '0;
    m_HGRANT[addr_owner_q] = 1'b1;
  end

  // Search starts at owner+1; the owner itself is tried last, and parks if nobody asks.
  always_comb begin
    int   cand;
    logic found;
    next_idx = addr_owner_q;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_MANAGERS; k++) begin
      cand = (aidx + k) % NUM_MANAGERS;
      if (!found && m_HBUSREQ[cand]) begin
        next_idx = IDX_W'(cand);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    last = 1'b0;
    case (own_trans)
      TR_IDLE:   last = 1'b1;
      TR_NONSEQ: last = (own_burst == BU_SINGLE) || (own_burst == BU_INCR && !own_req);
      TR_SEQ:    last = (beats_left_q == 5'd1) || (own_burst == BU_INCR && !own_req);
      default:   last = 1'b0;
    endcase
  end

  assign rearb = HREADY && last && !(own_lock && own_trans != TR_IDLE);

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    beats_left_d = beats_left_q;
    if (HREADY) begin
      data_owner_d = addr_owner_q;
      if (rearb) addr_owner_d = next_idx;
      case (own_trans)
        TR_NONSEQ: begin
          case (own_burst)
            3'd2, 3'd3: beats_left_d = 5'd3;
            3'd4, 3'd5: beats_left_d = 5'd7;
            3'd6, 3'd7: beats_left_d = 5'd15;
            default:    beats_left_d = 5'd0;
          endcase
        end
        TR_SEQ:  if (beats_left_q != 5'd0) beats_left_d = beats_left_q - 5'd1;
        TR_IDLE: beats_left_d = 5'd0;
        default: beats_left_d = beats_left_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
      beats_left_q <= 5'd0;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// Directed bench for renode_ahb_arbiter with two managers; inputs change and outputs are sampled 1ns after posedge.
module tb_renode_ahb_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  m_HBUSREQ, m_HMASTLOCK, m_HWRITE, m_HGRANT;
  logic [63:0] m_HADDR, m_HWDATA;
  logic [3:0]  m_HTRANS;
  logic [5:0]  m_HSIZE, m_HBURST;
  logic        HREADY;
  logic [31:0] s_HADDR, s_HWDATA;
  logic [1:0]  s_HTRANS;
  logic        s_HWRITE, s_HMASTLOCK;
  logic [2:0]  s_HSIZE, s_HBURST;
  logic        addr_owner, data_owner;

  int n_checks = 0;
  int n_errors = 0;

  renode_ahb_arbiter #(.NUM_MANAGERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_HBUSREQ(m_HBUSREQ), .m_HMASTLOCK(m_HMASTLOCK), .m_HADDR(m_HADDR),
    .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE),
    .m_HBURST(m_HBURST), .m_HWDATA(m_HWDATA), .m_HGRANT(m_HGRANT),
    .HREADY(HREADY),
    .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HMASTLOCK(s_HMASTLOCK),
    .s_HWDATA(s_HWDATA), .addr_owner(addr_owner), .data_owner(data_owner)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic [1:0] tr, input logic [2:0] bu,
                       input logic [31:0] ad, input logic wr, input logic lk);
    m_HBUSREQ[i]       = req;
    m_HTRANS[i*2 +: 2] = tr;
    m_HBURST[i*3 +: 3] = bu;
    m_HADDR[i*32 +: 32] = ad;
    m_HWRITE[i]        = wr;
    m_HMASTLOCK[i]     = lk;
  endtask

  initial begin
    HRESETn     = 1'b0;
    HREADY      = 1'b1;
    m_HBUSREQ   = '0;
    m_HMASTLOCK = '0;
    m_HADDR     = '0;
    m_HTRANS    = '0;
    m_HWRITE    = '0;
    m_HSIZE     = 6'b010_010;
    m_HBURST    = '0;
    m_HWDATA    = {32'h2222_2222, 32'h1111_1111};

    // Reset: M0 drives NONSEQ but the subordinate must see IDLE.
    set_m(0, 1'b0, 2'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_grant", 32'(m_HGRANT), 32'h1);
    chk("rst_htrans", 32'(s_HTRANS), 32'h0);
    chk("rst_addr_owner", 32'(addr_owner), 32'h0);
    chk("rst_data_owner", 32'(data_owner), 32'h0);
    set_m(0, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    HRESETn = 1'b1;

    // 1: no requests, parks on M0.
    for (int c = 0; c < 5; c++) step();
    chk("park_grant", 32'(m_HGRANT), 32'h1);
    chk("park_htrans", 32'(s_HTRANS), 32'h0);

    // 2: M1 requests, single write.
    set_m(1, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("m1_grant", 32'(m_HGRANT), 32'h2);
    chk("m1_addr_owner", 32'(addr_owner), 32'h1);
    set_m(1, 1'b0, 2'd2, 3'd0, 32'h100, 1'b1, 1'b0);
    #1;
    chk("m1_haddr", s_HADDR, 32'h100);
    chk("m1_htrans", 32'(s_HTRANS), 32'h2);
    chk("m1_hwrite", 32'(s_HWRITE), 32'h1);
    step();
    set_m(1, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    m_HWDATA[63:32] = 32'hDEAD_BEEF;
    #1;
    chk("m1_data_owner", 32'(data_owner), 32'h1);
    chk("m1_hwdata", s_HWDATA, 32'hDEAD_BEEF);
    chk("m1_parked", 32'(m_HGRANT), 32'h2);

    // 3: M0 INCR4 at 0x40 while M1 requests.
    set_m(0, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("m0_grant", 32'(m_HGRANT), 32'h1);
    set_m(1, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1'b1, (b == 0) ? 2'd2 : 2'd3, 3'd3, 32'h40 + 32'(b * 4), 1'b1, 1'b0);
      #1;
      chk("incr4_addr", s_HADDR, 32'h40 + 32'(b * 4));
      step();
      chk("incr4_hold", 32'(m_HGRANT), 32'h1);
    end
    set_m(0, 1'b1, 2'd3, 3'd3, 32'h4C, 1'b1, 1'b0);
    step();
    chk("incr4_handover", 32'(m_HGRANT), 32'h2);
    chk("incr4_data_owner", 32'(data_owner), 32'h0);
    set_m(0, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);

    // 4: both request SINGLE continuously -> 0,1,0,1.
    set_m(0, 1'b1, 2'd2, 3'd0, 32'h10, 1'b0, 1'b0);
    set_m(1, 1'b1, 2'd2, 3'd0, 32'h20, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      step();
      chk("rr_owner", 32'(addr_owner), 32'(t % 2));
      chk("rr_grant", 32'(m_HGRANT), (t % 2 == 0) ? 32'h1 : 32'h2);
    end
    set_m(0, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    set_m(1, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("rr_park", 32'(m_HGRANT), 32'h2);

    // 5: M0 locked pair of NONSEQ with a 3-cycle wait state.
    set_m(0, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lk_grant", 32'(m_HGRANT), 32'h1);
    chk("lk_data_owner0", 32'(data_owner), 32'h1);
    set_m(0, 1'b1, 2'd2, 3'd0, 32'h80, 1'b1, 1'b1);
    set_m(1, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("lk_mastlock", 32'(s_HMASTLOCK), 32'h1);
    step();
    chk("lk_first_hold", 32'(m_HGRANT), 32'h1);
    chk("lk_data_owner1", 32'(data_owner), 32'h0);
    set_m(0, 1'b1, 2'd2, 3'd0, 32'h84, 1'b1, 1'b1);
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk("lk_wait_grant", 32'(m_HGRANT), 32'h1);
      chk("lk_wait_data_owner", 32'(data_owner), 32'h0);
      chk("lk_wait_haddr", s_HADDR, 32'h84);
    end
    HREADY = 1'b1;
    step();
    chk("lk_second_hold", 32'(m_HGRANT), 32'h1);
    set_m(0, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lk_release", 32'(m_HGRANT), 32'h2);

    // 6: reset mid INCR8 of M1.
    set_m(0, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      set_m(1, 1'b1, (b == 0) ? 2'd2 : 2'd3, 3'd5, 32'h200 + 32'(b * 4), 1'b1, 1'b0);
      step();
      chk("incr8_hold", 32'(m_HGRANT), 32'h2);
    end
    set_m(0, 1'b1, 2'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(m_HGRANT), 32'h1);
    chk("mid_rst_addr_owner", 32'(addr_owner), 32'h0);
    chk("mid_rst_data_owner", 32'(data_owner), 32'h0);
    chk("mid_rst_htrans", 32'(s_HTRANS), 32'h0);
    step();
    set_m(0, 1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    set_m(1, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    #1;
    chk("post_rst_grant", 32'(m_HGRANT), 32'h1);
    step();
    chk("post_rst_rearb", 32'(m_HGRANT), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
